dma_bus_master: RTL and testbench

Bus-master sequencer for the SDMAC replacement. It arbitrates for the 68030 bus (_BR/_BG/_BGACK), enables Ramsey's address generator (_DMAEN) and runs bounded bursts of 32-bit DMA cycles on behalf of the SCSI FIFO. It sits between the register file (CNTR/ST_DMA/SP_DMA) and the CPU-side bus pins, beside the peripheral port that moves PD_PORT data.

---
 rtl/sdmac_pkg.sv | 33 +++
 rtl/bus_arbiter.sv | 68 ++++++
 rtl/dma_bus_master.sv | 159 +++++++++++++++
 tb/tb_dma_bus_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdmac_pkg.sv
// Shared definitions for the SDMAC bus-master sequencer: state encoding,
// parameter defaults and idle levels of the active-low bus lines.
package sdmac_pkg;

  localparam int unsigned BURST_MAX_DEF = 4;
  localparam int unsigned TMO_CYC_DEF   = 255;
  localparam int unsigned TMO_W         = 8;
  localparam int unsigned BCNT_W        = 4;

  localparam logic [BCNT_W-1:0] BCNT_SAT   = '1;
  localparam logic              N_IDLE     = 1'b1;
  localparam logic [1:0]        DSACK_IDLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAITFREE = 3'd2,
    ST_OWN      = 3'd3,
    ST_CYC      = 3'd4,
    ST_TERM     = 3'd5,
    ST_REL      = 3'd6
  } state_e;

  // The tenure lasts through REL so _BGACK/BUS_OE outlive the strobes by a clock.
  function automatic logic owns_bus(input state_e s);
    return (s == ST_OWN) || (s == ST_CYC) || (s == ST_TERM) || (s == ST_REL);
  endfunction

  function automatic logic strobing(input state_e s);
    return (s == ST_CYC) || (s == ST_TERM);
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// 68030 bus arbitration handshake: request, wait for a free bus, release.
// Supplies next state for the handshake states and drives _BR/_BGACK.
module bus_arbiter
  import sdmac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  state_e     state_q,
  input  state_e     state_d,
  input  logic       armed,
  input  logic       xfer_req,
  input  logic       sp_dma,
  input  logic       bg_n,
  input  logic       as_in_n,
  input  logic [1:0] dsack_in_n,
  input  logic       sterm_n,
  output state_e     arb_next_c,
  output logic       br_n,
  output logic       bgack_n
);

  logic abandon_c;
  logic bus_free_c;
  logic br_n_d, br_n_q;
  logic bgack_n_d, bgack_n_q;

  assign abandon_c  = sp_dma | ~armed;
  assign bus_free_c = as_in_n & (dsack_in_n == DSACK_IDLE) & sterm_n;

  // Handshake transitions; engine states are resolved by the top.
  always_comb begin
    arb_next_c = state_q;
    case (state_q)
      ST_IDLE:     if (!abandon_c && xfer_req) arb_next_c = ST_REQ;
      ST_REQ: begin
        if (abandon_c)  arb_next_c = ST_IDLE;
        else if (!bg_n) arb_next_c = ST_WAITFREE;
      end
      ST_WAITFREE: begin
        if (abandon_c)       arb_next_c = ST_IDLE;
        else if (bus_free_c) arb_next_c = ST_OWN;
      end
      ST_REL:      arb_next_c = ST_IDLE;
      default:     arb_next_c = state_q;
    endcase
  end

  always_comb begin
    br_n_d    = N_IDLE;
    bgack_n_d = N_IDLE;
    if (state_d == ST_REQ || state_d == ST_WAITFREE) br_n_d = 1'b0;
    if (owns_bus(state_d)) bgack_n_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_n_q    <= N_IDLE;
      bgack_n_q <= N_IDLE;
    end else begin
      br_n_q    <= br_n_d;
      bgack_n_q <= bgack_n_d;
    end
  end

  assign br_n    = br_n_q;
  assign bgack_n = bgack_n_q;

endmodule

// File: rtl/dma_bus_master.sv
// SDMAC bus-master sequencer: arms on ST_DMA, takes the 68030 bus and runs
// bounded bursts of longword cycles for the SCSI FIFO.
module dma_bus_master
  import sdmac_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEF,
  parameter int unsigned TMO_CYC   = TMO_CYC_DEF
) (
  input  logic       SCLK,
  input  logic       _RST,
  input  logic       DMAENA,
  input  logic       ST_DMA,
  input  logic       SP_DMA,
  input  logic       DMADIR,
  input  logic       XFER_REQ,
  input  logic       _BG,
  input  logic       _AS_IN,
  input  logic [1:0] _DSACK_IN,
  input  logic       _STERM,
  input  logic       _BERR,
  output logic       _BR,
  output logic       _BGACK,
  output logic       _DMAEN,
  output logic       _AS_O,
  output logic       _DS_O,
  output logic       R_W_O,
  output logic       BUS_OE,
  output logic       XFER_ACK,
  output logic       DMA_ACT,
  output logic       BERR_FLAG
);

  state_e state_q, state_d, arb_next_c;

  logic              armed_d, armed_q;
  logic              berr_d, berr_q;
  logic [BCNT_W-1:0] cnt_d, cnt_q;
  logic [TMO_W-1:0]  tmo_d, tmo_q;
  logic              strobe_n_d, strobe_n_q;
  logic              rw_d, rw_q;
  logic              oe_d, oe_q;
  logic              dmaen_n_d, dmaen_n_q;
  logic              ack_d, ack_q;
  logic              abort_c;
  logic              done_c;
  logic              tmo_exp_c;

  bus_arbiter u_arb (
    .clk        (SCLK),
    .rst_n      (_RST),
    .state_q    (state_q),
    .state_d    (state_d),
    .armed      (armed_q),
    .xfer_req   (XFER_REQ),
    .sp_dma     (SP_DMA),
    .bg_n       (_BG),
    .as_in_n    (_AS_IN),
    .dsack_in_n (_DSACK_IN),
    .sterm_n    (_STERM),
    .arb_next_c (arb_next_c),
    .br_n       (_BR),
    .bgack_n    (_BGACK)
  );

  assign done_c = ~_STERM | (_DSACK_IN != DSACK_IDLE);
  // Strobes stay out at most TMO_CYC clocks: expiry is the count reaching 0.
  assign tmo_exp_c = (tmo_q <= TMO_W'(1));

  // Next state; a bus error outranks a same-clock termination.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_REQ, ST_WAITFREE, ST_REL: state_d = arb_next_c;
      ST_OWN: begin
        if (armed_q && XFER_REQ && (cnt_q < BCNT_W'(BURST_MAX))) state_d = ST_CYC;
        else                                                      state_d = ST_REL;
      end
      ST_CYC: state_d = ST_TERM;
      ST_TERM: begin
        if (!_BERR) begin
          abort_c = 1'b1;
          state_d = ST_REL;
        end else if (done_c) begin
          ack_d   = 1'b1;
          state_d = ST_OWN;
        end else if (tmo_exp_c) begin
          abort_c = 1'b1;
          state_d = ST_REL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arming, error flag, burst/timeout counters and pin levels.
  always_comb begin
    armed_d = armed_q;
    berr_d  = berr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    if (abort_c || SP_DMA || !DMAENA) armed_d = 1'b0;
    else if (ST_DMA)                  armed_d = 1'b1;

    if (abort_c)                 berr_d = 1'b1;
    else if (ST_DMA && !SP_DMA)  berr_d = 1'b0;

    if (state_q == ST_REL)                cnt_d = '0;
    else if (ack_d && cnt_q != BCNT_SAT)  cnt_d = cnt_q + BCNT_W'(1);

    if (state_d == ST_CYC)
      tmo_d = TMO_W'(TMO_CYC);
    else if (strobing(state_q) && tmo_q != '0)
      tmo_d = tmo_q - TMO_W'(1);

    strobe_n_d = ~strobing(state_d);
    oe_d       = owns_bus(state_d);
    dmaen_n_d  = ~owns_bus(state_d);
    rw_d       = owns_bus(state_d) ? ~DMADIR : N_IDLE;
  end

  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      berr_q     <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      strobe_n_q <= N_IDLE;
      rw_q       <= N_IDLE;
      oe_q       <= 1'b0;
      dmaen_n_q  <= N_IDLE;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      berr_q     <= berr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      strobe_n_q <= strobe_n_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      dmaen_n_q  <= dmaen_n_d;
      ack_q      <= ack_d;
    end
  end

  assign _DMAEN    = dmaen_n_q;
  assign _AS_O     = strobe_n_q;
  assign _DS_O     = strobe_n_q;
  assign R_W_O     = rw_q;
  assign BUS_OE    = oe_q;
  assign XFER_ACK  = ack_q;
  assign DMA_ACT   = armed_q;
  assign BERR_FLAG = berr_q;

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: directed scenarios plus random bus traffic, all
// compared each clock against a tenure-level reference model.
module tb_dma_bus_master;

  localparam int BMAX = 4;
  localparam int TMO  = 10;

  logic       SCLK;
  logic       rst_n, dmaena, st_dma, sp_dma, dmadir, xfer_req;
  logic       bg_n, as_in_n, sterm_n, berr_n;
  logic [1:0] dsack_n;
  logic       br_n, bgack_n, dmaen_n, as_o_n, ds_o_n, r_w_o, bus_oe;
  logic       xfer_ack, dma_act, berr_flag;

  int n_checks = 0;
  int n_pass   = 0;
  bit auto_term = 0;

  // Reference model: request/grant flags, tenure flag, strobe age in clocks.
  bit m_armed, m_berr, m_br, m_granted, m_own, m_rel, m_ack, m_rw;
  int m_age, m_burst;

  dma_bus_master #(.BURST_MAX(BMAX), .TMO_CYC(TMO)) dut (
    .SCLK(SCLK), ._RST(rst_n), .DMAENA(dmaena), .ST_DMA(st_dma), .SP_DMA(sp_dma),
    .DMADIR(dmadir), .XFER_REQ(xfer_req), ._BG(bg_n), ._AS_IN(as_in_n),
    ._DSACK_IN(dsack_n), ._STERM(sterm_n), ._BERR(berr_n),
    ._BR(br_n), ._BGACK(bgack_n), ._DMAEN(dmaen_n), ._AS_O(as_o_n), ._DS_O(ds_o_n),
    .R_W_O(r_w_o), .BUS_OE(bus_oe), .XFER_ACK(xfer_ack), .DMA_ACT(dma_act),
    .BERR_FLAG(berr_flag)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_step();
    bit a, abandon, abort;
    if (!rst_n) begin
      m_armed = 0; m_berr = 0; m_br = 0; m_granted = 0; m_own = 0; m_rel = 0;
      m_ack = 0; m_rw = 1; m_age = 0; m_burst = 0;
      return;
    end
    a = m_armed;
    abandon = sp_dma || !a;
    abort = 0;
    m_ack = 0;
    if (m_rel) begin
      m_own = 0; m_rel = 0; m_burst = 0;
    end else if (m_own && m_age == 0) begin
      if (a && xfer_req && m_burst < BMAX) m_age = 1;
      else m_rel = 1;
    end else if (m_own && m_age == 1) begin
      m_age = 2;
    end else if (m_own) begin
      if (!berr_n) abort = 1;
      else if (!sterm_n || dsack_n != 2'b11) begin
        m_age = 0; m_ack = 1; m_burst = (m_burst < 15) ? m_burst + 1 : 15;
      end else if (m_age >= TMO) abort = 1;
      else m_age++;
      if (abort) begin m_age = 0; m_rel = 1; end
    end else if (m_br && !m_granted) begin
      if (abandon) m_br = 0;
      else if (!bg_n) m_granted = 1;
    end else if (m_br) begin
      if (abandon) begin m_br = 0; m_granted = 0; end
      else if (as_in_n && dsack_n == 2'b11 && sterm_n) begin
        m_br = 0; m_granted = 0; m_own = 1;
      end
    end else if (!abandon && xfer_req) begin
      m_br = 1;
    end
    m_rw = m_own ? !dmadir : 1'b1;
    if (abort || sp_dma || !dmaena) m_armed = 0;
    else if (st_dma) m_armed = 1;
    if (abort) m_berr = 1;
    else if (st_dma && !sp_dma) m_berr = 0;
  endtask

  task automatic compare_all();
    check("BR",        32'(br_n),      32'(!m_br));
    check("BGACK",     32'(bgack_n),   32'(!m_own));
    check("DMAEN",     32'(dmaen_n),   32'(!m_own));
    check("BUS_OE",    32'(bus_oe),    32'(m_own));
    check("AS_O",      32'(as_o_n),    32'(m_age == 0));
    check("DS_O",      32'(ds_o_n),    32'(m_age == 0));
    check("R_W_O",     32'(r_w_o),     32'(m_rw));
    check("XFER_ACK",  32'(xfer_ack),  32'(m_ack));
    check("DMA_ACT",   32'(dma_act),   32'(m_armed));
    check("BERR_FLAG", 32'(berr_flag), 32'(m_berr));
  endtask

  // One clock: DUT and model both consume the inputs present at the edge.
  task automatic step();
    @(posedge SCLK);
    model_step();
    #1;
    compare_all();
    if (auto_term) sterm_n = !(m_age > 0);
  endtask

  task automatic idle_inputs();
    st_dma = 0; sp_dma = 0; dmadir = 1; xfer_req = 1; dmaena = 1;
    bg_n = 1; as_in_n = 1; dsack_n = 2'b11; sterm_n = 1; berr_n = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
  endtask

  task automatic start_dma();
    st_dma = 1;
    step();
    st_dma = 0;
  endtask

  task automatic wait_as_low(input string tag);
    for (int i = 0; i < 50 && as_o_n !== 1'b0; i++) step();
    check(tag, 32'(as_o_n), 32'(0));
  endtask

  initial begin
    int acks, cnt;
    bit seen_own, strobe_now;

    // Reset with grant and request present must leave every line idle.
    idle_inputs();
    rst_n = 0; bg_n = 0;
    repeat (3) step();
    rst_n = 1;

    // Full burst: grant three clocks after start, fast termination.
    do_reset();
    auto_term = 1;
    start_dma();
    repeat (3) step();
    bg_n = 0;
    acks = 0; seen_own = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (xfer_ack) acks++;
      if (bgack_n == 1'b0) seen_own = 1;
      else if (seen_own) break;
    end
    check("burst_acks", 32'(acks), 32'(BMAX));
    check("burst_release", 32'(bgack_n), 32'(1));
    for (int i = 0; i < 10 && br_n !== 1'b0; i++) step();
    check("rerequest", 32'(br_n), 32'(0));
    auto_term = 0;

    // Grant while another master still drives _AS.
    do_reset();
    as_in_n = 0; bg_n = 0;
    start_dma();
    repeat (8) step();
    check("bgack_held", 32'(bgack_n), 32'(1));
    as_in_n = 1;
    step();
    check("bgack_after_as", 32'(bgack_n), 32'(0));

    // No termination: abort after TMO strobe clocks.
    do_reset();
    bg_n = 0;
    start_dma();
    wait_as_low("tmo_start");
    cnt = 1;
    for (int i = 0; i < 300 && as_o_n === 1'b0; i++) begin
      step();
      if (as_o_n === 1'b0) cnt++;
    end
    check("tmo_strobe_clks", 32'(cnt), 32'(TMO));
    check("tmo_berr", 32'(berr_flag), 32'(1));
    check("tmo_act", 32'(dma_act), 32'(0));
    step();
    check("tmo_release", 32'(bgack_n), 32'(1));
    repeat (3) step();
    check("tmo_no_rereq", 32'(br_n), 32'(1));

    // Stop while terminating: cycle finishes, then release with no new cycle.
    do_reset();
    bg_n = 0;
    start_dma();
    wait_as_low("stop_start");
    step();
    sp_dma = 1;
    step();
    sp_dma = 0;
    step();
    dsack_n = 2'b00;
    step();
    check("stop_ack", 32'(xfer_ack), 32'(1));
    dsack_n = 2'b11;
    cnt = 0;
    repeat (10) begin
      step();
      if (as_o_n === 1'b0) cnt++;
    end
    check("stop_no_cycle", 32'(cnt), 32'(0));
    check("stop_release", 32'(bgack_n), 32'(1));

    // Bus error mid-cycle: sticky flag until the next start.
    do_reset();
    bg_n = 0;
    start_dma();
    wait_as_low("berr_start");
    step();
    berr_n = 0;
    step();
    check("berr_set", 32'(berr_flag), 32'(1));
    berr_n = 1;
    step();
    check("berr_dmaen", 32'(dmaen_n), 32'(1));
    repeat (5) step();
    check("berr_sticky", 32'(berr_flag), 32'(1));
    start_dma();
    check("berr_clear", 32'(berr_flag), 32'(0));
    check("berr_rearm", 32'(dma_act), 32'(1));

    // Random traffic with a loosely cooperating bus.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      strobe_now = (m_age > 0);
      rst_n    = ($urandom_range(0, 599) != 0);
      dmaena   = ($urandom_range(0, 31) != 0);
      st_dma   = ($urandom_range(0, 11) == 0);
      sp_dma   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 63) == 0) dmadir = ~dmadir;
      xfer_req = ($urandom_range(0, 3) != 0);
      bg_n     = !(m_br && $urandom_range(0, 2) != 0);
      as_in_n  = ($urandom_range(0, 5) != 0);
      sterm_n  = strobe_now ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) != 0);
      dsack_n  = (strobe_now && $urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      berr_n   = strobe_now ? ($urandom_range(0, 40) != 0) : ($urandom_range(0, 200) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
